// File: rtl/arbiter_response_reader_if.sv
// Challenge/response handshake bundle for the arbiter PUF response reader.
interface arbiter_response_reader_if #(
  parameter int CHAL_W = 8
);
  logic              chal_valid;
  logic              chal_ready;
  logic [CHAL_W-1:0] challenge;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_bit;
  logic              resp_unstable;
  logic              resp_timeout;

  modport master (
    output chal_valid, challenge, resp_ready,
    input  chal_ready, resp_valid, resp_bit, resp_unstable, resp_timeout
  );

  modport slave (
    input  chal_valid, challenge, resp_ready,
    output chal_ready, resp_valid, resp_bit, resp_unstable, resp_timeout
  );
endinterface

// File: rtl/arbiter_response_reader.sv
// Arbiter PUF reader: applies a challenge, runs VOTES races, and reports a
// majority-voted response with instability and timeout flags.
//
// state | meaning
// IDLE  | waiting for a challenge, chal_ready high
// QUIET | chain held low until both outputs read 0 for SETTLE cycles
// RACE  | launch high, waiting for the first output to rise or a timeout
// TALLY | one cycle folding the race result into the vote counters
// DONE  | response held until the consumer accepts it
module arbiter_response_reader #(
  parameter int CHAL_W  = 8,
  parameter int VOTES   = 5,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  arbiter_response_reader_if.slave  bus,
  output logic [CHAL_W-1:0]         chal_out,
  output logic                      launch,
  input  logic                      race_x,
  input  logic                      race_y
);
  typedef enum logic [2:0] {S_IDLE, S_QUIET, S_RACE, S_TALLY, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LD  = 8'(SETTLE - 1);
  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT - 1);
  localparam logic [3:0] VOTES_C    = 4'(VOTES);
  localparam logic [3:0] HALF       = 4'(VOTES / 2);

  state_t      state, state_nxt;
  logic [1:0]  sync_x, sync_y;
  logic        x_s, y_s;
  logic        run;
  logic [7:0]  quiet_cnt, race_cnt;
  logic [3:0]  ones, votes_done, ones_sum;
  logic        win_x, tie_seen, to_seen;
  logic        resp_bit_q, resp_unstable_q, resp_timeout_q;
  logic        capture, quiet, resolved, race_to, last_vote;

  assign x_s       = sync_x[1];
  assign y_s       = sync_y[1];
  assign capture   = bus.chal_valid & bus.chal_ready;
  assign quiet     = ~x_s & ~y_s;
  assign resolved  = x_s | y_s;
  assign race_to   = ~resolved & (race_cnt == 8'd0);
  assign ones_sum  = ones + {3'b000, win_x};
  assign last_vote = (votes_done + 4'd1) == VOTES_C;

  assign bus.resp_bit      = resp_bit_q;
  assign bus.resp_unstable = resp_unstable_q;
  assign bus.resp_timeout  = resp_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (capture) state_nxt = S_QUIET;
      S_QUIET: if (quiet && quiet_cnt == 8'd0) state_nxt = S_RACE;
      S_RACE:  if (resolved || race_to) state_nxt = S_TALLY;
      S_TALLY: state_nxt = last_vote ? S_DONE : S_QUIET;
      S_DONE:  if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // run keeps chal_ready low for as long as reset is held.
  always_comb begin
    bus.chal_ready = 1'b0;
    bus.resp_valid = 1'b0;
    launch         = 1'b0;
    case (state)
      S_IDLE:  bus.chal_ready = run;
      S_RACE:  launch = 1'b1;
      S_DONE:  bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run             <= 1'b0;
      sync_x          <= 2'b00;
      sync_y          <= 2'b00;
      chal_out        <= '0;
      quiet_cnt       <= 8'd0;
      race_cnt        <= 8'd0;
      ones            <= 4'd0;
      votes_done      <= 4'd0;
      win_x           <= 1'b0;
      tie_seen        <= 1'b0;
      to_seen         <= 1'b0;
      resp_bit_q      <= 1'b0;
      resp_unstable_q <= 1'b0;
      resp_timeout_q  <= 1'b0;
    end else begin
      run    <= 1'b1;
      sync_x <= {sync_x[0], race_x};
      sync_y <= {sync_y[0], race_y};
      case (state)
        S_IDLE: begin
          if (capture) begin
            chal_out   <= bus.challenge;
            ones       <= 4'd0;
            votes_done <= 4'd0;
            tie_seen   <= 1'b0;
            to_seen    <= 1'b0;
            quiet_cnt  <= SETTLE_LD;
          end
        end
        S_QUIET: begin
          race_cnt <= TIMEOUT_LD;
          if (!quiet)                  quiet_cnt <= SETTLE_LD;
          else if (quiet_cnt != 8'd0)  quiet_cnt <= quiet_cnt - 8'd1;
        end
        S_RACE: begin
          // a simultaneous rise counts as a loss for x and marks the vote unstable
          if (resolved) begin
            win_x <= x_s & ~y_s;
            if (x_s && y_s) tie_seen <= 1'b1;
          end else if (race_cnt == 8'd0) begin
            win_x   <= 1'b0;
            to_seen <= 1'b1;
          end else begin
            race_cnt <= race_cnt - 8'd1;
          end
        end
        S_TALLY: begin
          ones       <= ones_sum;
          votes_done <= votes_done + 4'd1;
          quiet_cnt  <= SETTLE_LD;
          if (last_vote) begin
            resp_bit_q      <= ones_sum > HALF;
            resp_unstable_q <= ((ones_sum != 4'd0) && (ones_sum != VOTES_C)) || tie_seen;
            resp_timeout_q  <= to_seen;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arbiter_response_reader.sv
// Self-checking bench: a behavioural race chain model feeds the reader and a
// vote-count reference predicts each response.
module tb_arbiter_response_reader;
  localparam int CHAL_W  = 8;
  localparam int VOTES   = 5;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CHAL_W-1:0] chal_out;
  logic              launch;
  logic              race_x, race_y;
  logic              chain_x = 1'b0, chain_y = 1'b0, force_y = 1'b0;

  arbiter_response_reader_if #(.CHAL_W(CHAL_W)) bus ();

  arbiter_response_reader #(
    .CHAL_W(CHAL_W), .VOTES(VOTES), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .chal_out(chal_out),
    .launch(launch), .race_x(race_x), .race_y(race_y)
  );

  always #5 clk = ~clk;

  assign race_x = chain_x;
  assign race_y = chain_y | force_y;

  int tests = 0, fails = 0;
  int dx_plan[16], dy_plan[16];
  int race_i = 0, n_launch = 0, cur_w = 0, lcnt = 0;
  int cur_dx = NEVER, cur_dy = NEVER;
  int widths[$];
  logic l_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chain model: each output rises a planned number of cycles after launch,
  // and both fall once launch is withdrawn.
  initial forever begin
    @(posedge clk); #1;
    if (launch && !l_prev) begin
      n_launch++;
      cur_w = 0;
      lcnt  = 0;
      if (race_i < 16) begin
        cur_dx = dx_plan[race_i];
        cur_dy = dy_plan[race_i];
      end
      race_i++;
    end
    if (launch) begin
      cur_w++;
      chain_x = (lcnt >= cur_dx);
      chain_y = (lcnt >= cur_dy);
      lcnt++;
    end else begin
      if (l_prev) widths.push_back(cur_w);
      chain_x = 1'b0;
      chain_y = 1'b0;
    end
    l_prev = launch;
  end

  function automatic void model(output logic eb, output logic eu, output logic et);
    int  n1 = 0;
    bit  tie = 0, to = 0;
    for (int i = 0; i < VOTES; i++) begin
      if (dx_plan[i] >= NEVER && dy_plan[i] >= NEVER) to = 1;
      else if (dx_plan[i] == dy_plan[i])              tie = 1;
      else if (dx_plan[i] < dy_plan[i])               n1++;
    end
    eb = (n1 > VOTES / 2);
    eu = ((n1 != 0) && (n1 != VOTES)) || tie;
    et = to;
  endfunction

  task automatic set_plan(input int i, input int dx, input int dy);
    dx_plan[i] = dx;
    dy_plan[i] = dy;
  endtask

  task automatic send(input logic [CHAL_W-1:0] c);
    bit rdy = 0;
    race_i   = 0;
    n_launch = 0;
    widths.delete();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.chal_ready) begin rdy = 1; break; end
    end
    check("chal_ready_wait", 32'(rdy), 32'd1);
    bus.chal_valid = 1'b1;
    bus.challenge  = c;
    @(posedge clk); #1;
    bus.chal_valid = 1'b0;
  endtask

  task automatic finish(input logic [CHAL_W-1:0] c, input int hold);
    bit   got = 0;
    logic eb, eu, et;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) begin got = 1; break; end
    end
    check("resp_valid_wait", 32'(got), 32'd1);
    model(eb, eu, et);
    check("resp_bit", 32'(bus.resp_bit), 32'(eb));
    check("resp_unstable", 32'(bus.resp_unstable), 32'(eu));
    check("resp_timeout", 32'(bus.resp_timeout), 32'(et));
    check("chal_out", 32'(chal_out), 32'(c));
    check("launch_pulses", 32'(n_launch), 32'(VOTES));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_ready", 32'(bus.chal_ready), 32'd0);
      check("hold_bits", {29'd0, bus.resp_bit, bus.resp_unstable, bus.resp_timeout},
            {29'd0, eb, eu, et});
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    check("idle_ready", 32'(bus.chal_ready), 32'd1);
  endtask

  initial begin
    int   gap;
    int   held_launch;
    bit   seen;
    logic [CHAL_W-1:0] c;
    bus.chal_valid = 1'b0;
    bus.challenge  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) set_plan(i, NEVER, NEVER);

    #12;
    check("rst_chal_ready", 32'(bus.chal_ready), 32'd0);
    check("rst_launch", 32'(launch), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_chal_out", 32'(chal_out), 32'd0);
    check("rst_resp_bits", {29'd0, bus.resp_bit, bus.resp_unstable, bus.resp_timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_ready", 32'(bus.chal_ready), 32'd1);

    // x always three cycles ahead; a second challenge offered mid-run must be ignored
    for (int i = 0; i < VOTES; i++) set_plan(i, 2, 5);
    send(8'hA5);
    @(negedge clk);
    bus.chal_valid = 1'b1;
    bus.challenge  = 8'h5A;
    repeat (5) @(negedge clk);
    bus.chal_valid = 1'b0;
    finish(8'hA5, 0);

    // y first in three races, x first in two
    set_plan(0, 6, 2); set_plan(1, 2, 6); set_plan(2, 7, 3);
    set_plan(3, 1, 4); set_plan(4, 5, 1);
    send(8'h3C);
    finish(8'h3C, 0);

    for (int i = 0; i < VOTES; i++) set_plan(i, 4, 4);
    send(8'hFF);
    finish(8'hFF, 0);

    for (int i = 0; i < VOTES; i++) set_plan(i, NEVER, NEVER);
    send(8'h01);
    finish(8'h01, 0);
    check("timeout_pulse_count", 32'(widths.size()), 32'(VOTES));
    foreach (widths[i]) check("timeout_width", 32'(widths[i]), 32'(TIMEOUT));

    // y held high through the start of QUIET delays the first launch
    for (int i = 0; i < VOTES; i++) set_plan(i, 3, 8);
    force_y = 1'b1;
    send(8'h77);
    held_launch = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (launch) held_launch++;
    end
    check("no_launch_while_noisy", 32'(held_launch), 32'd0);
    @(negedge clk);
    force_y = 1'b0;
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (launch) begin gap = i; break; end
    end
    check("settle_gap", 32'(gap), 32'(SETTLE + 2));
    finish(8'h77, 0);

    for (int i = 0; i < VOTES; i++) set_plan(i, 6, 2);
    send(8'h42);
    finish(8'h42, 20);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < VOTES; i++) begin
        set_plan(i, ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 10)),
                    ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 10)));
      end
      c = CHAL_W'($urandom);
      send(c);
      finish(c, 0);
    end

    // reset in the middle of a race drops everything at once
    for (int i = 0; i < VOTES; i++) set_plan(i, 20, 30);
    send(8'h99);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (launch) begin seen = 1; break; end
    end
    check("launch_before_reset", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrace_launch", 32'(launch), 32'd0);
    check("midrace_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrace_chal_ready", 32'(bus.chal_ready), 32'd0);
    check("midrace_chal_out", 32'(chal_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(bus.chal_ready), 32'd1);
    check("post_reset_valid", 32'(bus.resp_valid), 32'd0);

    for (int i = 0; i < VOTES; i++) set_plan(i, 2, 9);
    send(8'h18);
    finish(8'h18, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/arbiter_response_reader.md
ARBITER_RESPONSE_READER -- requirements
Module: arbiter_response_reader

Interface
REQ-001 Parameter CHAL_W, default 8, challenge width (one select bit per switch stage).
REQ-002 Parameter VOTES, default 5, race evaluations per challenge, odd, 1..15.
REQ-003 Parameter SETTLE, default 4, cycles the chain is held quiet before each launch, 1..255.
REQ-004 Parameter TIMEOUT, default 64, cycles allowed for a race to resolve, 2..255.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 chal_valid  in  1  challenge offered.
REQ-008 chal_ready  out  1  block can accept a challenge.
REQ-009 challenge  in  CHAL_W  challenge word.
REQ-010 chal_out  out  CHAL_W  registered challenge driving the stage select lines.
REQ-011 launch  out  1  edge injected into both chain inputs.
REQ-012 race_x, race_y  in  1 each  chain outputs, asynchronous; each passes a 2-flop synchronizer inside the block.
REQ-013 resp_valid  out  1  response available.
REQ-014 resp_ready  in  1  consumer accepts response.
REQ-015 resp_bit  out  1  majority response.
REQ-016 resp_unstable  out  1  votes not unanimous.
REQ-017 resp_timeout  out  1  at least one race timed out.

Function
REQ-018 States: IDLE, QUIET, RACE, TALLY, DONE.
REQ-019 IDLE: chal_ready=1; chal_valid&chal_ready captures challenge into chal_out, clears vote counters, -> QUIET.
REQ-020 QUIET: launch=0; counter runs while synchronized x and y are both 0, reloads whenever either is 1; after SETTLE consecutive quiet cycles -> RACE with launch=1 from the next cycle.
REQ-021 RACE: launch=1; first sampled cycle with x=1,y=0 records win_x=1; x=0,y=1 records win_x=0; x=1,y=1 in the same sample is a tie, recorded win_x=0 and flagged unstable; -> TALLY.
REQ-022 RACE lasting TIMEOUT cycles with neither output high: vote recorded win_x=0, resp_timeout flag set, -> TALLY.
REQ-023 TALLY (one cycle): ones += win_x, votes_done += 1, launch=0; votes_done==VOTES -> DONE, else -> QUIET.
REQ-024 resp_bit = (ones > VOTES/2); resp_unstable = (ones != 0 and ones != VOTES) or any tie; both registered on DONE entry.
REQ-025 DONE: resp_valid=1, outputs stable until resp_valid&resp_ready; then -> IDLE, resp_valid=0 next cycle.
REQ-026 chal_out holds unchanged from capture until the next capture; chal_valid outside IDLE is ignored.
REQ-027 Counter widths: ones, votes_done 4 bits; quiet and race counters 8 bits; no wrap possible within parameter limits.
REQ-028 Latency per vote = 2 (synchronizer) + SETTLE + race resolve + 1 cycles; back-to-back challenges allowed, IDLE lasts >=1 cycle.

Reset
REQ-029 rst_n=0 forces immediately: state IDLE, launch=0, chal_out=0, resp_valid=0, resp_bit=0, resp_unstable=0, resp_timeout=0, chal_ready=0 while asserted, all counters and synchronizers 0.
REQ-030 Reset mid-race or in DONE discards the pending response; after release chal_ready=1 in the first clock.

Verification
REQ-031 VOTES=5, race_x rises 3 cycles before race_y in every race -> resp_bit=1, unstable=0, timeout=0, 5 launch pulses observed.
REQ-032 race_y first in 3 races, race_x first in 2 -> resp_bit=0, resp_unstable=1.
REQ-033 race_x and race_y rise in the same cycle every race -> resp_bit=0, resp_unstable=1.
REQ-034 chain outputs stuck 0, TIMEOUT=64 -> each race ends after 64 cycles, resp_timeout=1, resp_bit=0.
REQ-035 race_y held 1 during QUIET for 10 cycles -> no launch until SETTLE quiet cycles after it drops.
REQ-036 resp_ready held 0 for 20 cycles in DONE -> resp_valid and response stable, chal_ready=0; rst_n pulse mid-RACE -> launch=0 and resp_valid=0 immediately.
